// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage.
package pipe_pkg;

    localparam int unsigned DEF_DATA_W = 96;
    localparam int unsigned DEF_RD_W   = 5;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/flopenr.sv
// Parametrised-width register with write enable and synchronous active-high reset to zero.
module flopenr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/pipeline_stage_hs.sv
// Elastic pipeline stage: valid/ready handshake, two-entry skid buffer, flush,
// forwarding tap and saturating stall/bubble counters.
module pipeline_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_W   = DEF_RD_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned ENTRY_W = DATA_W + RD_W + 1;

    state_t             state, state_nxt;
    logic               in_fire, out_fire;
    logic               main_en, skid_en;
    logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;

    assign in_ready  = (state != ST_TWO);
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign in_entry  = {in_data, in_rd, in_we};

    always_ff @(posedge clk) begin
        if (reset) state <= ST_EMPTY;
        else       state <= state_nxt;
    end

    // Next state and entry write enables; flush overrides any handshake.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_entry;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_en   = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en   = 1'b1;
                    state_nxt = ST_TWO;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                main_d = skid_q;
                if (out_fire) begin
                    main_en   = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_en   = 1'b0;
            skid_en   = 1'b0;
        end
    end

    flopenr #(.WIDTH(ENTRY_W)) u_main (
        .clk  (clk),
        .reset(reset),
        .en   (main_en),
        .d    (main_d),
        .q    (main_q)
    );

    flopenr #(.WIDTH(ENTRY_W)) u_skid (
        .clk  (clk),
        .reset(reset),
        .en   (skid_en),
        .d    (in_entry),
        .q    (skid_q)
    );

    assign {out_data, out_rd, out_we} = main_q;
    assign fwd_valid = out_valid & out_we & (out_rd != '0);
    assign fwd_rd    = out_rd;

    // Saturating performance counters; flush leaves them running.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (out_ready && !out_valid && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stage_hs.sv
// Directed self-checking bench for pipeline_stage_hs (default widths plus a CNT_W=4 copy).
module tb_pipeline_stage_hs;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_we, out_ready;
    logic [95:0] in_data;
    logic [4:0]  in_rd;
    logic        in_ready, out_valid, out_we, fwd_valid;
    logic [95:0] out_data;
    logic [4:0]  out_rd, fwd_rd;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        s_flush, s_in_valid, s_in_we, s_out_ready;
    logic [95:0] s_in_data;
    logic [4:0]  s_in_rd;
    logic        s_in_ready, s_out_valid, s_out_we, s_fwd_valid;
    logic [95:0] s_out_data;
    logic [4:0]  s_out_rd, s_fwd_rd;
    logic [3:0]  s_stall_cnt, s_bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_stage_hs dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipeline_stage_hs #(.DATA_W(96), .RD_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_rd(s_in_rd), .in_we(s_in_we),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_rd(s_out_rd), .out_we(s_out_we),
        .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d, input int rd, input logic we);
        in_valid = v;
        in_data  = 96'(d);
        in_rd    = 5'(rd);
        in_we    = we;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; drive(1'b1, 'h77, 3, 1'b1);
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_rd = '0; s_in_we = 1'b0; s_out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0; drive(1'b0, 0, 0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_data !== 96'h0 || out_rd !== 5'd0 || out_we !== 1'b0)
            begin failures++; $display("FAIL reset_out_fields got=%0h/%0d/%0b exp=0/0/0", out_data, out_rd, out_we); end
        checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid got=%0b exp=0", fwd_valid); end
        checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0)
            begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
        checks++; if (s_bubble_cnt !== 4'd0 || s_stall_cnt !== 4'd0)
            begin failures++; $display("FAIL reset_sat_counters got=%0d/%0d exp=0/0", s_stall_cnt, s_bubble_cnt); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, i, 1'b1);
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 96'(i) || out_rd !== 5'(i))
                begin failures++; $display("FAIL stream_beat%0d got=v%0b d=%0h rd=%0d exp=v1 d=%0h rd=%0d", i, out_valid, out_data, out_rd, i, i); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready%0d got=%0b exp=1", i, in_ready); end
            if (i == 1) begin
                checks++; if (bubble_cnt !== 16'd1) begin failures++; $display("FAIL stream_bubble_first got=%0d exp=1", bubble_cnt); end
            end
        end
        drive(1'b0, 0, 0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
        tick(); tick(); tick();
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
        checks++; if (bubble_cnt !== 16'd4) begin failures++; $display("FAIL stream_bubble got=%0d exp=4", bubble_cnt); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(1'b1, 'hA, 10, 1'b1);
        tick();
        checks++; if (out_data !== 96'hA || in_ready !== 1'b1)
            begin failures++; $display("FAIL skid_first got=d%0h r%0b exp=dA r1", out_data, in_ready); end
        drive(1'b1, 'hB, 11, 1'b1);
        tick();
        drive(1'b0, 0, 0, 1'b0);
        checks++; if (dut.state !== ST_TWO || in_ready !== 1'b0)
            begin failures++; $display("FAIL skid_full got=st%0d r%0b exp=st2 r0", dut.state, in_ready); end
        checks++; if (out_data !== 96'hA || stall_cnt !== 16'd1)
            begin failures++; $display("FAIL skid_hold1 got=d%0h s%0d exp=dA s1", out_data, stall_cnt); end
        tick();
        checks++; if (out_data !== 96'hA || stall_cnt !== 16'd2)
            begin failures++; $display("FAIL skid_hold2 got=d%0h s%0d exp=dA s2", out_data, stall_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 96'hB || out_rd !== 5'd11 || in_ready !== 1'b1)
            begin failures++; $display("FAIL skid_second got=v%0b d%0h rd%0d r%0b exp=v1 dB rd11 r1", out_valid, out_data, out_rd, in_ready); end
        checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL skid_stall_after got=%0d exp=2", stall_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_no_dup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 'h11, 1, 1'b1); tick();
        drive(1'b1, 'h12, 2, 1'b1); tick();
        checks++; if (dut.state !== ST_TWO) begin failures++; $display("FAIL flush_setup got=%0d exp=2", dut.state); end
        flush = 1'b1; drive(1'b1, 'hC, 12, 1'b1);
        tick();
        flush = 1'b0; drive(1'b0, 0, 0, 1'b0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL flush_empty got=v%0b r%0b exp=v0 r1", out_valid, in_ready); end
        checks++; if (stall_cnt !== 16'd4) begin failures++; $display("FAIL flush_stall got=%0d exp=4", stall_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data !== 96'h11)
                begin failures++; $display("FAIL flush_discard%0d got=v%0b d%0h exp=v0 d11", i, out_valid, out_data); end
        end
        checks++; if (bubble_cnt !== 16'd6) begin failures++; $display("FAIL flush_bubble got=%0d exp=6", bubble_cnt); end
    endtask

    task automatic test_forwarding();
        out_ready = 1'b0;
        drive(1'b1, 'h20, 0, 1'b1); tick();
        checks++; if (out_valid !== 1'b1 || fwd_valid !== 1'b0)
            begin failures++; $display("FAIL fwd_x0 got=v%0b f%0b exp=v1 f0", out_valid, fwd_valid); end
        out_ready = 1'b1;
        drive(1'b1, 'h21, 7, 1'b1); tick();
        checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7)
            begin failures++; $display("FAIL fwd_rd7 got=f%0b rd%0d exp=f1 rd7", fwd_valid, fwd_rd); end
        drive(1'b1, 'h22, 7, 1'b0); tick();
        checks++; if (out_valid !== 1'b1 || fwd_valid !== 1'b0)
            begin failures++; $display("FAIL fwd_we0 got=v%0b f%0b exp=v1 f0", out_valid, fwd_valid); end
        drive(1'b0, 0, 0, 1'b0); tick();
    endtask

    task automatic test_saturation();
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 96'h5A; s_in_rd = 5'd2; s_in_we = 1'b1;
        tick();
        s_in_valid = 1'b0;
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 96'h5A || s_out_rd !== 5'd2 || s_out_we !== 1'b1)
            begin failures++; $display("FAIL sat_load got=v%0b d%0h rd%0d we%0b exp=v1 d5a rd2 we1", s_out_valid, s_out_data, s_out_rd, s_out_we); end
        checks++; if (s_in_ready !== 1'b1 || s_fwd_valid !== 1'b1 || s_fwd_rd !== 5'd2)
            begin failures++; $display("FAIL sat_taps got=r%0b f%0b rd%0d exp=r1 f1 rd2", s_in_ready, s_fwd_valid, s_fwd_rd); end
        for (int i = 0; i < 14; i++) tick();
        checks++; if (s_stall_cnt !== 4'hE) begin failures++; $display("FAIL sat_14 got=%0h exp=e", s_stall_cnt); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (s_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_20 got=%0h exp=f", s_stall_cnt); end
        s_flush = 1'b1; tick(); s_flush = 1'b0;
        checks++; if (s_stall_cnt !== 4'hF || s_out_valid !== 1'b0)
            begin failures++; $display("FAIL sat_flush got=s%0h v%0b exp=sf v0", s_stall_cnt, s_out_valid); end
        checks++; if (s_bubble_cnt !== 4'd0) begin failures++; $display("FAIL sat_bubble got=%0d exp=0", s_bubble_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 'h55, 3, 1'b1); tick();
        checks++; if (dut.state !== ST_ONE) begin failures++; $display("FAIL rstmid_setup got=%0d exp=1", dut.state); end
        drive(1'b1, 'h66, 4, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        drive(1'b0, 0, 0, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_data !== 96'h0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL rstmid_out got=v%0b d%0h r%0b exp=v0 d0 r1", out_valid, out_data, in_ready); end
        checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0)
            begin failures++; $display("FAIL rstmid_counters got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
        checks++; if (dut.u_skid.q !== '0) begin failures++; $display("FAIL rstmid_skid got=%0h exp=0", dut.u_skid.q); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_forwarding();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_hs.md
# pipeline_stage_hs

Elastic, parametrised pipeline stage register for the rvpipeline datapath. It generalises the fixed per-field stage registers into one configurable-width stage with a valid/ready handshake, a two-entry skid buffer, synchronous flush, destination-register forwarding taps and saturating stall/bubble counters. It is instantiated between any two pipeline stages, first at M→W, so that a multi-cycle memory or writeback unit can backpressure the pipeline without losing instructions.

## Interface
- DATA_W, 96: payload width; the instantiating stage concatenates its fields, e.g. ALUResult, ReadData and ImmExt.
- RD_W, 5: destination-register index width.
- CNT_W, 16: width of each performance counter.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush from the hazard unit.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  payload.
- in_rd  in  RD_W  destination register.
- in_we  in  1  register-write enable of the beat.
- out_valid  out  1  head beat valid.
- out_ready  in  1  downstream accepts the head beat.
- out_data / out_rd / out_we  out  DATA_W / RD_W / 1  head beat fields.
- fwd_valid  out  1  equals out_valid & out_we & (out_rd != 0).
- fwd_rd  out  RD_W  equals out_rd; hazard-unit forwarding tap.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready.
- bubble_cnt  out  CNT_W  cycles with out_ready & !out_valid.

## Operation
- Storage is a main entry, which drives the out_* ports, and a skid entry. Each entry holds {data, rd, we}.
- State machine with states ST_EMPTY, ST_ONE and ST_TWO.
- Handshake terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Output decode:
  - in_ready = (state != ST_TWO). It is decoded from the registered state only and never depends on out_ready.
  - out_valid = (state != ST_EMPTY).
- Transitions:
  - ST_EMPTY:
    - in_fire: main ← in, go to ST_ONE.
  - ST_ONE:
    - in_fire & out_fire: main ← in, stay in ST_ONE.
    - in_fire only: skid ← in, go to ST_TWO.
    - out_fire only: go to ST_EMPTY.
  - ST_TWO:
    - out_fire: main ← skid, go to ST_ONE.
    - in_fire cannot occur in this state.
- Entries are written only on the transitions listed above. They hold their value otherwise, including while stalled.
- Priority order: reset > flush > handshake.
- flush:
  - State goes to ST_EMPTY.
  - A beat presented in the same cycle is discarded, even if in_ready=1.
  - A head beat completing out_fire in that cycle is still considered delivered.
  - Entry contents are not cleared.
- Counters:
  - Increment per their definitions and saturate at all-ones.
  - Cleared by reset only. flush does not affect them.
  - They count during flush cycles using the pre-flush out_valid.
- fwd_valid masks rd=0 (x0) so that x0 is never forwarded.

## Timing
- Reset values:
  - state = ST_EMPTY.
  - out_valid = 0, in_ready = 1.
  - out_data = 0, out_rd = 0, out_we = 0, and the skid entry is zeroed.
  - fwd_valid = 0, stall_cnt = 0, bubble_cnt = 0.
- Handshakes presented during a reset cycle are ignored.
- Latency: a beat accepted at edge N appears on out_* after edge N, i.e. one cycle of latency. Its earliest out_fire is in cycle N+1.
- Throughput is one beat per cycle when out_ready is held at 1. The skid entry is never used in that case.
- in_ready drops the cycle after the second beat is buffered. It rises the cycle after out_fire in ST_TWO.
- Reset mid-operation: all buffered beats are lost and the outputs take their reset values at the next edge.
- Reset or flush in ST_TWO: both entries are invalidated in one cycle.

## Structure
- pipe_pkg holds:
  - The state typedef, 2 bits: ST_EMPTY=0, ST_ONE=1, ST_TWO=2.
  - Default widths DATA_W=96, RD_W=5, CNT_W=16.
- One sub-module: flopenr, a parametrised-width register with synchronous active-high reset to 0 and a write enable. It is instantiated once for the main entry and once for the skid entry, each {DATA_W+RD_W+1} bits wide.
- The state register and counters are inline.

## Test plan
- Streaming:
  - Stimulus: reset, then beats 0x1..0x8 (rd=1..8, we=1) with out_ready=1.
  - Required: each beat is out one cycle after acceptance, in_ready stays 1, stall_cnt=0, and bubble_cnt counts only the idle cycles.
- Skid:
  - Stimulus: in_valid=1 with 0xA then 0xB, while out_ready=0.
  - Required: state reaches ST_TWO and in_ready=0; out_data holds 0xA; stall_cnt increments every cycle.
  - Then raise out_ready: 0xA and then 0xB are delivered in order, with no loss or duplication.
- Flush:
  - Stimulus: in ST_TWO, assert flush with in_valid=1 carrying 0xC.
  - Required: out_valid=0 and in_ready=1 next cycle, and 0xC never appears.
- Forwarding:
  - Stimulus 1: head beat rd=0 with we=1. Required: fwd_valid=0.
  - Stimulus 2: rd=7 with we=1. Required: fwd_valid=1, fwd_rd=7.
  - Stimulus 3: rd=7 with we=0. Required: fwd_valid=0.
- Saturation:
  - Stimulus: CNT_W=4, out_valid=1 held with out_ready=0 for 20 cycles.
  - Required: stall_cnt=0xF; a subsequent flush leaves it at 0xF.
- Reset mid-stream:
  - Stimulus: assert reset while in ST_ONE and in_valid=1.
  - Required: next cycle out_valid=0, out_data=0, counters 0, in_ready=1.
